// File: rtl/arith_serial_unit_if.sv
// Handshake and operand/result bundle for arith_serial_unit.
// master drives requests (ALU control side), slave is the serial engine.
interface arith_serial_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, cin, sel,
        input  busy, done, d, cout, ovf, zero
    );

    modport slave (
        input  start, a, b, cin, sel,
        output busy, done, d, cout, ovf, zero
    );
endinterface

// File: rtl/arith_serial_unit.sv
// Digit-serial adder/subtractor: WIDTH-bit A op B, DIGIT bits per clock, start/done handshake.
// Optional ARITH_SAT_EN: saturate d to the signed limit on overflow.
module arith_serial_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input logic                clk,
    input logic                rst,
    arith_serial_unit_if.slave bus
);
    localparam int unsigned K  = WIDTH / DIGIT;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("arith_serial_unit: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, d_q;
    logic             carry_q, busy_q, done_q, cout_q, ovf_q, zero_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0]       b_sel;
    logic [DIGIT-1:0]       sum;
    logic                   c_msb_in, c_out;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next, fin_d;
    logic                   fin_ovf, last;

    always_comb begin
        case (bus.sel)
            2'b00:   b_sel = bus.b;
            2'b01:   b_sel = ~bus.b;
            2'b10:   b_sel = '0;
            default: b_sel = '1;
        endcase
    end

    // Ripple through the digit; the carry entering the top bit feeds overflow on the last digit.
    always_comb begin
        logic cy;
        cy       = carry_q;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb_in = cy;
            sum[i]   = a_sr_q[i] ^ b_sr_q[i] ^ cy;
            cy       = (a_sr_q[i] & b_sr_q[i]) | (cy & (a_sr_q[i] ^ b_sr_q[i]));
        end
        c_out = cy;
    end

    assign res_cat  = {sum, res_sr_q};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign fin_ovf  = c_msb_in ^ c_out;
    assign last     = (cnt_q == CW'(K - 1));

`ifdef ARITH_SAT_EN
    logic a_msb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
        end else if (state_q == StIdle && bus.start) begin
            a_msb_q <= bus.a[WIDTH-1];
        end
    end

    always_comb begin
        if (fin_ovf) begin
            fin_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_d = res_next;
        end
    end
`else
    assign fin_d = res_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_sr_q   <= bus.a;
                        b_sr_q   <= b_sel;
                        carry_q  <= bus.cin;
                        res_sr_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                default: begin
                    a_sr_q   <= a_sr_q >> DIGIT;
                    b_sr_q   <= b_sr_q >> DIGIT;
                    carry_q  <= c_out;
                    res_sr_q <= res_next;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        d_q     <= fin_d;
                        cout_q  <= c_out;
                        ovf_q   <= fin_ovf;
                        zero_q  <= (fin_d == '0);
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_arith_serial_unit.sv
// Directed self-checking bench for arith_serial_unit (DIGIT=2 main, DIGIT=1 and 8 side instances).
// Expectations follow ARITH_SAT_EN when the bench is built with it.
module tb_arith_serial_unit;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    arith_serial_unit_if #(.WIDTH(8)) bus ();
    arith_serial_unit_if #(.WIDTH(8)) bus1 ();
    arith_serial_unit_if #(.WIDTH(8)) bus8 ();

    arith_serial_unit #(.WIDTH(8), .DIGIT(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    arith_serial_unit #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    arith_serial_unit #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

`ifdef ARITH_SAT_EN
    localparam logic [7:0] ExpOvfAdd = 8'h7F;
    localparam logic [7:0] ExpOvfDec = 8'h80;
`else
    localparam logic [7:0] ExpOvfAdd = 8'h81;
    localparam logic [7:0] ExpOvfDec = 8'h7F;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] s, input logic [7:0] av,
                          input logic [7:0] bv, input logic c, input logic [7:0] ed,
                          input logic ec, input logic eo, input logic ez);
        int lat;
        bus.sel   = s;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = 8'($urandom());
        bus.b     = 8'($urandom());
        bus.cin   = 1'($urandom());
        bus.sel   = 2'($urandom());
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " d"}, 32'(bus.d), 32'(ed));
        check({tag, " cout"}, 32'(bus.cout), 32'(ec));
        check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
        check({tag, " zero"}, 32'(bus.zero), 32'(ez));
        tick();
        check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    endtask

    logic [1:0] s5_sel [3] = '{2'b00, 2'b01, 2'b11};
    logic [7:0] s5_a   [3] = '{8'h3C, 8'h10, 8'h00};
    logic [7:0] s5_b   [3] = '{8'h45, 8'h10, 8'h00};
    logic       s5_cin [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] s5_d   [3] = '{ExpOvfAdd, 8'h00, 8'hFF};
    logic       s5_z   [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int lat1, lat8;
        bool_init: begin
            bus.start  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0; bus.sel  = 2'b00;
            bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sel = 2'b00;
            bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sel = 2'b00;
        end
        rst = 1'b1;
        tick();
        tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset d", 32'(bus.d), 32'd0);
        check("reset flags", 32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add ovf", 2'b00, 8'h3C, 8'h45, 1'b0, ExpOvfAdd, 1'b0, 1'b1, 1'b0);

        // Abort mid-run: reset two cycles after acceptance.
        bus.sel = 2'b00; bus.a = 8'h7F; bus.b = 8'h01; bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort d", 32'(bus.d), 32'd0);
        check("abort flags", 32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort no done", 32'(bus.done), 32'd0);
        end

        run_op("sub eq", 2'b01, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub neg", 2'b01, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("dec zero", 2'b11, 8'h00, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op("inc ff", 2'b10, 8'hFF, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("dec min", 2'b11, 8'h80, 8'h00, 1'b0, ExpOvfDec, 1'b1, 1'b1, 1'b0);

        // start held high: accepts only on done cycles, operands scrambled mid-run.
        bus.sel = s5_sel[0]; bus.a = s5_a[0]; bus.b = s5_b[0]; bus.cin = s5_cin[0];
        bus.start = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (t % 5 == 4) begin
                check("b2b done", 32'(bus.done), 32'd1);
                check("b2b d", 32'(bus.d), 32'(s5_d[t / 5]));
                check("b2b zero", 32'(bus.zero), 32'(s5_z[t / 5]));
                if (t / 5 < 2) begin
                    bus.sel = s5_sel[t / 5 + 1];
                    bus.a   = s5_a[t / 5 + 1];
                    bus.b   = s5_b[t / 5 + 1];
                    bus.cin = s5_cin[t / 5 + 1];
                end
            end else begin
                check("b2b idle done", 32'(bus.done), 32'd0);
                bus.a   = 8'($urandom());
                bus.b   = 8'($urandom());
                bus.cin = 1'($urandom());
                bus.sel = 2'($urandom());
            end
        end
        bus.start = 1'b0;
        tick();

        // Same add on DIGIT=1 and DIGIT=8 instances.
        bus1.sel = 2'b00; bus1.a = 8'h3C; bus1.b = 8'h45; bus1.cin = 1'b0;
        bus8.sel = 2'b00; bus8.a = 8'h3C; bus8.b = 8'h45; bus8.cin = 1'b0;
        bus1.start = 1'b1;
        bus8.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        bus8.start = 1'b0;
        lat1 = 0;
        lat8 = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus1.done === 1'b1 && lat1 == 0) lat1 = t;
            if (bus8.done === 1'b1 && lat8 == 0) lat8 = t;
        end
        check("digit1 latency", 32'(lat1), 32'd8);
        check("digit8 latency", 32'(lat8), 32'd1);
        check("digit1 d", 32'(bus1.d), 32'(ExpOvfAdd));
        check("digit8 d", 32'(bus8.d), 32'(ExpOvfAdd));
        check("digit1 flags", 32'({bus1.cout, bus1.ovf, bus1.zero}), 32'b010);
        check("digit8 flags", 32'({bus8.cout, bus8.ovf, bus8.zero}), 32'b010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
